lbp_histogram: RTL

Downstream consumer of the LBP engine's output stream. Snoops the same `lbp_valid`/`lbp_addr`/`lbp_data` write bus that fills the LBP result memory, accumulates a 256-bin histogram of LBP codes over one 128x128 frame, and drains the bins serially over a valid/ready port when the engine raises `finish`. Bins are cleared as they are read, so the block is ready for the next frame without a separate clear pass.

---
 rtl/lbp_histogram_if.sv | 30 +++
 rtl/lbp_histogram.sv | 105 ++++++++++
 2 files changed

// File: rtl/lbp_histogram_if.sv
// Bus bundle between the LBP engine write port, the histogram block and the bin sink.
// The slave view belongs to the histogram; the master view drives it.
interface lbp_histogram_if #(
    parameter int IMG_W_LOG2 = 7
);
    localparam int ADDR_W = 2 * IMG_W_LOG2;
    localparam int CNT_W  = 2 * IMG_W_LOG2 + 1;

    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              hist_valid;
    logic              hist_ready;
    logic [7:0]        hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              hist_done;
    logic              busy;
    logic              drop_err;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        input  hist_valid, hist_bin, hist_count, hist_done, busy, drop_err
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
        output hist_valid, hist_bin, hist_count, hist_done, busy, drop_err
    );
endinterface

// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes over one frame; bins drain over valid/ready on a
// rising finish and are cleared as they are read, ready for the next frame.
module lbp_histogram #(
    parameter bit SKIP_BORDER = 1'b1,
    parameter int IMG_W_LOG2  = 7
) (
    input  logic            clk,
    input  logic            reset,
    lbp_histogram_if.slave  bus
);
    localparam int ADDR_W = 2 * IMG_W_LOG2;
    localparam int CNT_W  = 2 * IMG_W_LOG2 + 1;
    localparam logic [IMG_W_LOG2-1:0] EDGE_MAX = '1;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DRAIN,
        ST_WAIT_LOW
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       rd_ptr_q, rd_ptr_d;
    logic             finish_q;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] bins_q [256];

    logic [IMG_W_LOG2-1:0] row, col;
    logic                  on_border;
    logic                  count_en;
    logic                  accept;
    logic                  finish_rise;

    assign row         = bus.lbp_addr[ADDR_W-1:IMG_W_LOG2];
    assign col         = bus.lbp_addr[IMG_W_LOG2-1:0];
    assign on_border   = (row == '0) || (row == EDGE_MAX) || (col == '0) || (col == EDGE_MAX);
    assign count_en    = (state_q == ST_ACC) && bus.lbp_valid && !(SKIP_BORDER && on_border);
    assign accept      = (state_q == ST_DRAIN) && bus.hist_ready;
    assign finish_rise = bus.finish && !finish_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = 1'b0;
        drop_d   = drop_q || (bus.lbp_valid && (state_q != ST_ACC));
        unique case (state_q)
            ST_ACC: begin
                if (finish_rise) begin
                    state_d  = ST_DRAIN;
                    rd_ptr_d = 8'd0;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    rd_ptr_d = rd_ptr_q + 8'd1;
                    if (rd_ptr_q == 8'hFF) begin
                        done_d  = 1'b1;
                        state_d = ST_WAIT_LOW;
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (!bus.finish) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q  <= ST_ACC;
            rd_ptr_q <= 8'd0;
            finish_q <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            finish_q <= bus.finish;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: the bins must read as zero straight after reset, so they are flops with a reset
    // rather than a RAM; counting and drain-clearing never coincide because they live in
    // different states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) bins_q[i] <= '0;
        end else begin
            if (count_en) bins_q[bus.lbp_data] <= bins_q[bus.lbp_data] + CNT_W'(1);
            if (accept)   bins_q[rd_ptr_q]     <= '0;
        end
    end

    assign bus.hist_valid = (state_q == ST_DRAIN);
    assign bus.hist_bin   = (state_q == ST_DRAIN) ? rd_ptr_q : 8'd0;
    assign bus.hist_count = (state_q == ST_DRAIN) ? bins_q[rd_ptr_q] : '0;
    assign bus.hist_done  = done_q;
    assign bus.busy       = (state_q == ST_DRAIN);
    assign bus.drop_err   = drop_q;
endmodule
